pooling_stream: RTL
===================

POOLING_STREAM -- requirements
Module: pooling_stream

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, sample and result width.
REQ-002 Parameter: WINDOW, default 64, window length; power of two, >= 2; PTR_WIDTH = clog2(WINDOW), SUM_WIDTH = DATA_WIDTH + PTR_WIDTH.
REQ-003 Port: clk  input  1  single clock, all state on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  in_data valid.
REQ-006 Port: in_ready  output  1  block accepts sample this cycle.
REQ-007 Port: in_data  input  DATA_WIDTH  unsigned sample.
REQ-008 Port: mode  input  2  00 sliding avg, 01 block max, 10 block min, 11 block avg.
REQ-009 Port: clear  input  1  synchronous flush of all window state.
REQ-010 Port: out_valid  output  1  out_data valid.
REQ-011 Port: out_ready  input  1  downstream accepts out_data.
REQ-012 Port: out_data  output  DATA_WIDTH  pooled result (mu).
REQ-013 Port: fill  output  PTR_WIDTH+1  samples currently held in window/history.

Function
REQ-014 Accept = in_valid && in_ready; in_ready = !clear && (mode == mode_q) && (!out_valid || out_ready).
REQ-015 mode_q: internal registered mode; when mode != mode_q, that cycle is an implicit clear (per REQ-024) and mode_q <= mode; no sample accepted that cycle.
REQ-016 Output register: one entry; out_valid set the cycle after a producing accept; cleared on out_valid && out_ready without new producing accept; out_data stable while out_valid && !out_ready.
REQ-017 Sliding avg (00): history of WINDOW samples, ptr wraps WINDOW-1 -> 0; per accept sum <= sum - history[ptr] + in_data, history[ptr] <= in_data, ptr++.
REQ-018 Sliding avg emits one result per accepted sample, latency 1 cycle: out_data = (updated sum) >> PTR_WIDTH, floor; unfilled history slots count as 0.
REQ-019 Sliding avg: fill increments per accept, saturates at WINDOW.
REQ-020 Block modes (01/10/11): non-overlapping windows; cnt counts accepts 0..WINDOW-1; accumulator updated per accept: max, min, or sum (SUM_WIDTH, cannot overflow).
REQ-021 Block modes emit one result on the WINDOW-th accept, latency 1 cycle, result includes that sample; avg = sum >> PTR_WIDTH (floor).
REQ-022 After emission accumulator reseeds: max -> 0, min -> all ones, sum -> 0; cnt -> 0; fill -> 0.
REQ-023 fill in block modes = cnt; fill reaches WINDOW never (resets to 0 on emission).
REQ-024 clear (explicit or implicit): next state history all 0, sum 0, ptr 0, cnt 0, fill 0, accumulators reseeded per mode_q-next, out_valid 0; any in_valid sample that cycle is not accepted.
REQ-025 clear has priority over accept and over output handshake; a pending out_data is dropped by clear.
REQ-026 Backpressure: accept in same cycle as out_ready-drain permitted; new result replaces drained one, out_valid stays 1.

Reset
REQ-027 rst_n low: out_valid 0, out_data 0, fill 0, history 0, sum 0, ptr 0, cnt 0, max acc 0, min acc all ones, mode_q 00.
REQ-028 Reset mid-window/mid-handshake discards all partial results; first cycle after release with mode != 00 is an implicit clear.
REQ-029 in_ready 0 during reset.

Verification (DATA_WIDTH=8, WINDOW=4, out_ready=1 unless stated)
REQ-030 Mode 00, samples 4,8,12,16,20 -> out_data 1,3,6,10,14, each 1 cycle after accept; fill 1,2,3,4,4.
REQ-031 Mode 01, samples 3,9,2,7 then 1,1,1,1 -> exactly two results: 9, then 1 (reseed verified).
REQ-032 Mode 10, samples 5,200,3,50 -> 3; mode 11, samples 255,255,255,255 -> 255 (no overflow).
REQ-033 Mode 11 result pending, out_ready 0 for 5 cycles -> in_ready 0, out_data/out_valid stable; out_ready 1 -> drained, in_ready 1.
REQ-034 Mode 01, samples 9,9, clear pulse, then 1,2,3,4 -> single result 4; fill 2 -> 0 after clear.
REQ-035 Mode 11, two samples accepted, mode changed to 01 -> one cycle in_ready 0, fill 0, no output; next 4 samples 6,2,8,1 -> 8.

Source files
------------

// File: rtl/pooling_stream.sv
// Streaming pooling unit: sliding-window average or non-overlapping block max/min/avg
// over unsigned samples, with a single-entry output register and valid/ready handshakes.
module pooling_stream #(
  parameter  int DATA_WIDTH = 8,
  parameter  int WINDOW     = 64,
  localparam int PTR_WIDTH  = $clog2(WINDOW),
  localparam int SUM_WIDTH  = DATA_WIDTH + PTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            mode,
  input  logic                  clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [PTR_WIDTH:0]    fill
);

  typedef enum logic [1:0] {
    MODE_SLIDE = 2'b00,
    MODE_MAX   = 2'b01,
    MODE_MIN   = 2'b10,
    MODE_AVG   = 2'b11
  } mode_e;

  localparam logic [PTR_WIDTH:0]   FILL_MAX   = (PTR_WIDTH+1)'(WINDOW);
  localparam logic [PTR_WIDTH-1:0] BLOCK_LAST = PTR_WIDTH'(WINDOW - 1);

  mode_e                 mode_q;
  logic [DATA_WIDTH-1:0] history [WINDOW];
  logic [SUM_WIDTH-1:0]  sum_q, sum_d;
  logic [PTR_WIDTH-1:0]  ptr_q, ptr_d, cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] max_q, max_d, min_q, min_d;
  logic [PTR_WIDTH:0]    fill_q, fill_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic                  flush, accept, block_last;
  logic [SUM_WIDTH-1:0]  in_ext, old_ext, slide_sum, block_sum;
  logic [DATA_WIDTH-1:0] max_upd, min_upd;

  // A mode change behaves exactly like an explicit clear for one cycle.
  assign flush    = clear || (mode != mode_q);
  assign in_ready = rst_n && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign in_ext     = SUM_WIDTH'(in_data);
  assign old_ext    = SUM_WIDTH'(history[ptr_q]);
  assign slide_sum  = sum_q - old_ext + in_ext;
  assign block_sum  = sum_q + in_ext;
  assign max_upd    = (in_data > max_q) ? in_data : max_q;
  assign min_upd    = (in_data < min_q) ? in_data : min_q;
  assign block_last = (cnt_q == BLOCK_LAST);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign fill      = fill_q;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    sum_d       = sum_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    max_d       = max_q;
    min_d       = min_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (flush) begin
      sum_d       = '0;
      ptr_d       = '0;
      cnt_d       = '0;
      max_d       = '0;
      min_d       = '1;
      fill_d      = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (accept) begin
        if (mode_q == MODE_SLIDE) begin
          sum_d       = slide_sum;
          ptr_d       = ptr_q + PTR_WIDTH'(1);
          if (fill_q != FILL_MAX) fill_d = fill_q + (PTR_WIDTH+1)'(1);
          out_valid_d = 1'b1;
          out_data_d  = DATA_WIDTH'(slide_sum >> PTR_WIDTH);
        end else if (block_last) begin
          // Window complete: emit with this sample included, then reseed.
          sum_d       = '0;
          max_d       = '0;
          min_d       = '1;
          cnt_d       = '0;
          fill_d      = '0;
          out_valid_d = 1'b1;
          case (mode_q)
            MODE_MAX: out_data_d = max_upd;
            MODE_MIN: out_data_d = min_upd;
            default:  out_data_d = DATA_WIDTH'(block_sum >> PTR_WIDTH);
          endcase
        end else begin
          sum_d  = block_sum;
          max_d  = max_upd;
          min_d  = min_upd;
          cnt_d  = cnt_q + PTR_WIDTH'(1);
          fill_d = fill_q + (PTR_WIDTH+1)'(1);
        end
      end
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_SLIDE;
      sum_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      max_q       <= '0;
      min_q       <= '1;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      mode_q      <= mode_e'(mode);
      sum_q       <= sum_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      min_q       <= min_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // NOTE: history is reset because the sliding sum subtracts old entries; stale data would corrupt it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WINDOW; i++) history[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < WINDOW; i++) history[i] <= '0;
    end else if (accept && (mode_q == MODE_SLIDE)) begin
      history[ptr_q] <= in_data;
    end
  end

endmodule
